// File: rtl/snitch_shared_muldiv_arbiter.sv
// Purpose: shares one MUL/DIV accelerator port among NrCores cores. Requests are arbitrated round-robin and tagged with the core index; responses are routed back by tag.
// Latency: a core request handshake at cycle t is presented downstream at t+1; the response path is combinational (zero latency).
// Backpressure: the request register holds its payload while acc_req_ready_i is low; the response ready mirrors the addressed core's ready.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   core_req_*                per-core request streams (valid/ready, id, op, arga, argb)
//   core_resp_*               per-core response valid/ready plus a shared id/data/error bus
//   acc_req_*                 registered downstream request with the core index as tag
//   acc_resp_*                downstream response carrying the tag back
module snitch_shared_muldiv_arbiter #(
    parameter int unsigned NrCores        = 4,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned IdWidth        = 5,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned TagWidth       = $clog2(NrCores)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NrCores-1:0]                  core_req_valid_i,
    output logic [NrCores-1:0]                  core_req_ready_o,
    input  logic [NrCores-1:0][IdWidth-1:0]     core_req_id_i,
    input  logic [NrCores-1:0][31:0]            core_req_op_i,
    input  logic [NrCores-1:0][DataWidth-1:0]   core_req_arga_i,
    input  logic [NrCores-1:0][DataWidth-1:0]   core_req_argb_i,
    output logic [NrCores-1:0]                  core_resp_valid_o,
    input  logic [NrCores-1:0]                  core_resp_ready_i,
    output logic [IdWidth-1:0]                  core_resp_id_o,
    output logic [DataWidth-1:0]                core_resp_data_o,
    output logic                                core_resp_error_o,
    output logic                                acc_req_valid_o,
    input  logic                                acc_req_ready_i,
    output logic [TagWidth-1:0]                 acc_req_tag_o,
    output logic [IdWidth-1:0]                  acc_req_id_o,
    output logic [31:0]                         acc_req_op_o,
    output logic [DataWidth-1:0]                acc_req_arga_o,
    output logic [DataWidth-1:0]                acc_req_argb_o,
    input  logic                                acc_resp_valid_i,
    output logic                                acc_resp_ready_o,
    input  logic [TagWidth-1:0]                 acc_resp_tag_i,
    input  logic [IdWidth-1:0]                  acc_resp_id_i,
    input  logic [DataWidth-1:0]                acc_resp_data_i,
    input  logic                                acc_resp_error_i
);

    localparam int unsigned          CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0]  CntMax   = CntWidth'(MaxOutstanding);
    localparam logic [TagWidth:0]    NrCoresW = (TagWidth+1)'(NrCores);
    localparam logic [TagWidth-1:0]  LastCore = TagWidth'(NrCores - 1);

    typedef struct packed {
        logic [TagWidth-1:0]  tag;
        logic [IdWidth-1:0]   id;
        logic [31:0]          op;
        logic [DataWidth-1:0] arga;
        logic [DataWidth-1:0] argb;
    } acc_req_t;

    acc_req_t                          req_q;
    acc_req_t                          gnt_req;
    logic [TagWidth-1:0]               rr_q;
    logic [NrCores-1:0][CntWidth-1:0]  cnt_q;

    logic [NrCores-1:0]  eligible;
    logic [NrCores-1:0]  req_hs;
    logic [NrCores-1:0]  resp_hit;
    logic [NrCores-1:0]  resp_hs;
    logic                tag_in_range;
    logic                load;
    logic                gnt_vld;
    logic [TagWidth-1:0] gnt_idx;
    logic [TagWidth:0]   scan_sum;
    logic [TagWidth-1:0] scan_idx;

    // A core may only compete while it still has an in-flight slot left.
    always_comb begin
        eligible = '0;
        for (int unsigned k = 0; k < NrCores; k++) begin
            eligible[k] = core_req_valid_i[k] && (cnt_q[k] < CntMax);
        end
    end

    // The register can take a new request when empty or draining this cycle.
    assign load = !acc_req_valid_o || acc_req_ready_i;

    // Scan from rr_q upwards with wrap-around; the first eligible core wins.
    // The sum stays below 2*NrCores, so one conditional subtract is the modulo.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NrCores; i++) begin
            scan_sum = {1'b0, rr_q} + (TagWidth+1)'(i);
            scan_idx = (scan_sum >= NrCoresW) ? TagWidth'(scan_sum - NrCoresW)
                                              : TagWidth'(scan_sum);
            if (!gnt_vld && eligible[scan_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // Ready is withheld during reset so no handshake is seen while state clears.
    always_comb begin
        core_req_ready_o = '0;
        if (load && gnt_vld && !rst_i) begin
            core_req_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign req_hs = core_req_ready_o & core_req_valid_i;

    always_comb begin
        gnt_req      = '0;
        gnt_req.tag  = gnt_idx;
        gnt_req.id   = core_req_id_i[gnt_idx];
        gnt_req.op   = core_req_op_i[gnt_idx];
        gnt_req.arga = core_req_arga_i[gnt_idx];
        gnt_req.argb = core_req_argb_i[gnt_idx];
    end

    // Tag decode by comparison keeps out-of-range tags (non power-of-2 core
    // counts) from indexing past the per-core vectors.
    always_comb begin
        resp_hit = '0;
        for (int unsigned k = 0; k < NrCores; k++) begin
            resp_hit[k] = (acc_resp_tag_i == TagWidth'(k));
        end
    end

    assign tag_in_range      = |resp_hit;
    assign core_resp_valid_o = {NrCores{acc_resp_valid_i}} & resp_hit;
    // An unroutable response is swallowed so the downstream unit never stalls on it.
    assign acc_resp_ready_o  = tag_in_range ? |(resp_hit & core_resp_ready_i) : 1'b1;
    assign resp_hs           = core_resp_valid_o & core_resp_ready_i;
    assign core_resp_id_o    = acc_resp_id_i;
    assign core_resp_data_o  = acc_resp_data_i;
    assign core_resp_error_o = acc_resp_error_i;

    assign acc_req_tag_o  = req_q.tag;
    assign acc_req_id_o   = req_q.id;
    assign acc_req_op_o   = req_q.op;
    assign acc_req_arga_o = req_q.arga;
    assign acc_req_argb_o = req_q.argb;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_req_valid_o <= 1'b0;
            req_q           <= '0;
            rr_q            <= '0;
            cnt_q           <= '0;
        end else begin
            if (load) begin
                acc_req_valid_o <= gnt_vld;
                if (gnt_vld) begin
                    req_q <= gnt_req;
                    rr_q  <= (gnt_idx == LastCore) ? '0 : gnt_idx + TagWidth'(1);
                end
            end
            // Simultaneous issue and retire cancel out; both directions saturate.
            for (int unsigned k = 0; k < NrCores; k++) begin
                case ({req_hs[k], resp_hs[k]})
                    2'b10: if (cnt_q[k] != CntMax) cnt_q[k] <= cnt_q[k] + CntWidth'(1);
                    2'b01: if (cnt_q[k] != '0)     cnt_q[k] <= cnt_q[k] - CntWidth'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snitch_shared_muldiv_arbiter.sv
// Purpose: self-checking bench for the shared MUL/DIV arbiter against a reference model.
// Latency: model expects downstream request one cycle after the core handshake.
// Backpressure: exercised with held downstream ready and stalled core response ready.
module tb_snitch_shared_muldiv_arbiter;

    localparam int N   = 4;
    localparam int MAX = 2;
    localparam int IW  = 5;
    localparam int DW  = 32;
    localparam int TW  = 2;

    logic                    clk = 1'b0;
    logic                    rst_i;
    logic [N-1:0]            core_req_valid_i;
    logic [N-1:0]            core_req_ready_o;
    logic [N-1:0][IW-1:0]    core_req_id_i;
    logic [N-1:0][31:0]      core_req_op_i;
    logic [N-1:0][DW-1:0]    core_req_arga_i;
    logic [N-1:0][DW-1:0]    core_req_argb_i;
    logic [N-1:0]            core_resp_valid_o;
    logic [N-1:0]            core_resp_ready_i;
    logic [IW-1:0]           core_resp_id_o;
    logic [DW-1:0]           core_resp_data_o;
    logic                    core_resp_error_o;
    logic                    acc_req_valid_o;
    logic                    acc_req_ready_i;
    logic [TW-1:0]           acc_req_tag_o;
    logic [IW-1:0]           acc_req_id_o;
    logic [31:0]             acc_req_op_o;
    logic [DW-1:0]           acc_req_arga_o;
    logic [DW-1:0]           acc_req_argb_o;
    logic                    acc_resp_valid_i;
    logic                    acc_resp_ready_o;
    logic [TW-1:0]           acc_resp_tag_i;
    logic [IW-1:0]           acc_resp_id_i;
    logic [DW-1:0]           acc_resp_data_i;
    logic                    acc_resp_error_i;

    snitch_shared_muldiv_arbiter #(
        .NrCores(N), .MaxOutstanding(MAX), .IdWidth(IW), .DataWidth(DW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
        .core_req_id_i(core_req_id_i), .core_req_op_i(core_req_op_i),
        .core_req_arga_i(core_req_arga_i), .core_req_argb_i(core_req_argb_i),
        .core_resp_valid_o(core_resp_valid_o), .core_resp_ready_i(core_resp_ready_i),
        .core_resp_id_o(core_resp_id_o), .core_resp_data_o(core_resp_data_o),
        .core_resp_error_o(core_resp_error_o),
        .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
        .acc_req_tag_o(acc_req_tag_o), .acc_req_id_o(acc_req_id_o),
        .acc_req_op_o(acc_req_op_o), .acc_req_arga_o(acc_req_arga_o),
        .acc_req_argb_o(acc_req_argb_o),
        .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_ready_o(acc_resp_ready_o),
        .acc_resp_tag_i(acc_resp_tag_i), .acc_resp_id_i(acc_resp_id_i),
        .acc_resp_data_i(acc_resp_data_i), .acc_resp_error_i(acc_resp_error_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: outstanding count per core, next priority core,
    // and the request the downstream port should currently present.
    int           m_cnt [N];
    int           m_rr;
    bit           m_vld;
    int           m_tag;
    logic [IW-1:0] m_id;
    logic [31:0]  m_op;
    logic [DW-1:0] m_a, m_b;

    int           exp_gnt;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_resp_vld;
    logic         exp_acc_resp_rdy;

    typedef struct { int tag; logic [IW-1:0] id; } dq_t;
    dq_t dq [$];
    int  resp_idx;

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
        m_rr = 0; m_vld = 0; m_tag = 0; m_id = '0; m_op = '0; m_a = '0; m_b = '0;
        dq.delete();
    endtask

    task automatic model_eval();
        bit ld;
        exp_gnt = -1;
        ld = !m_vld || acc_req_ready_i;
        if (ld && !rst_i) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_rr + i) % N;
                if (exp_gnt < 0 && core_req_valid_i[k] && m_cnt[k] < MAX) exp_gnt = k;
            end
        end
        exp_ready        = (exp_gnt >= 0) ? (N'(1) << exp_gnt) : '0;
        exp_resp_vld     = acc_resp_valid_i ? (N'(1) << acc_resp_tag_i) : '0;
        exp_acc_resp_rdy = core_resp_ready_i[acc_resp_tag_i];
    endtask

    // Advance model and DUT by one clock, then settle 1 time unit past the edge.
    task automatic step();
        model_eval();
        if (rst_i) begin
            model_reset();
        end else begin
            if (m_vld && acc_req_ready_i) dq.push_back('{m_tag, m_id});
            for (int k = 0; k < N; k++) begin
                bit inc, dec;
                inc = (exp_gnt == k);
                dec = acc_resp_valid_i && (int'(acc_resp_tag_i) == k) && core_resp_ready_i[k];
                if (inc && !dec && m_cnt[k] < MAX) m_cnt[k]++;
                else if (dec && !inc && m_cnt[k] > 0) m_cnt[k]--;
            end
            if (acc_resp_valid_i && core_resp_ready_i[acc_resp_tag_i] && resp_idx >= 0)
                dq.delete(resp_idx);
            if (!m_vld || acc_req_ready_i) begin
                if (exp_gnt >= 0) begin
                    m_vld = 1; m_tag = exp_gnt;
                    m_id = core_req_id_i[exp_gnt]; m_op = core_req_op_i[exp_gnt];
                    m_a = core_req_arga_i[exp_gnt]; m_b = core_req_argb_i[exp_gnt];
                    m_rr = (exp_gnt + 1) % N;
                end else begin
                    m_vld = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req_valid_i = '0; acc_req_ready_i = 1'b0; acc_resp_valid_i = 1'b0;
        acc_resp_tag_i = '0; acc_resp_id_i = '0; acc_resp_data_i = '0;
        acc_resp_error_i = 1'b0; core_resp_ready_i = '0; resp_idx = -1;
    endtask

    task automatic rand_payload();
        for (int k = 0; k < N; k++) begin
            core_req_id_i[k]   = IW'($urandom);
            core_req_op_i[k]   = $urandom;
            core_req_arga_i[k] = $urandom;
            core_req_argb_i[k] = $urandom;
        end
    endtask

    task automatic do_reset();
        idle(); rst_i = 1'b1; step(); rst_i = 1'b0;
    endtask

    task automatic test_reset();
        idle(); rand_payload(); rst_i = 1'b1; core_req_valid_i = '1; acc_req_ready_i = 1'b1;
        #1;
        checks++; if (core_req_ready_o !== '0) begin errors++; $display("FAIL reset_ready got %b exp 0000", core_req_ready_o); end
        checks++; if (core_resp_valid_o !== '0) begin errors++; $display("FAIL reset_resp_vld got %b exp 0000", core_resp_valid_o); end
        step();
        checks++; if (acc_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_acc_vld got %b exp 0", acc_req_valid_o); end
        checks++; if ({acc_req_tag_o, acc_req_id_o, acc_req_op_o, acc_req_arga_o, acc_req_argb_o} !== '0) begin
            errors++; $display("FAIL reset_payload got tag %h id %h op %h exp all zero", acc_req_tag_o, acc_req_id_o, acc_req_op_o); end
        step();
        rst_i = 1'b0; idle();
    endtask

    task automatic test_rr_order();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rand_payload();
            core_req_valid_i = '1; acc_req_ready_i = 1'b1; core_resp_ready_i = '1;
            acc_resp_valid_i = m_vld; acc_resp_tag_i = TW'(m_tag); acc_resp_id_i = m_id; resp_idx = -1;
            model_eval(); #1;
            checks++; if (core_req_ready_o !== (N'(1) << (i % N))) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, core_req_ready_o, N'(1) << (i % N)); end
            checks++; if (core_req_ready_o !== exp_ready) begin errors++; $display("FAIL rr_model[%0d] got %b exp %b", i, core_req_ready_o, exp_ready); end
            checks++; if (core_resp_valid_o !== exp_resp_vld) begin errors++; $display("FAIL rr_resp[%0d] got %b exp %b", i, core_resp_valid_o, exp_resp_vld); end
            step();
            checks++; if (acc_req_valid_o !== 1'b1 || acc_req_tag_o !== TW'(i % N)) begin errors++; $display("FAIL rr_tag[%0d] got v%b t%0d exp v1 t%0d", i, acc_req_valid_o, acc_req_tag_o, i % N); end
            checks++; if (acc_req_id_o !== m_id || acc_req_arga_o !== m_a) begin errors++; $display("FAIL rr_payload[%0d] got %h/%h exp %h/%h", i, acc_req_id_o, acc_req_arga_o, m_id, m_a); end
        end
        idle();
    endtask

    task automatic test_max_outstanding();
        logic [N-1:0] seq [4];
        seq = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rand_payload(); core_req_valid_i = 4'b0100; acc_req_ready_i = 1'b1;
            model_eval(); #1;
            checks++; if (core_req_ready_o !== seq[i] || core_req_ready_o !== exp_ready) begin errors++; $display("FAIL maxout_ready[%0d] got %b exp %b", i, core_req_ready_o, seq[i]); end
            step();
        end
        acc_resp_valid_i = 1'b1; acc_resp_tag_i = 2'd2; core_resp_ready_i = 4'b0100;
        #1;
        checks++; if (core_req_ready_o !== 4'b0000) begin errors++; $display("FAIL maxout_full got %b exp 0000", core_req_ready_o); end
        checks++; if (core_resp_valid_o !== 4'b0100 || acc_resp_ready_o !== 1'b1) begin errors++; $display("FAIL maxout_resp got %b/%b exp 0100/1", core_resp_valid_o, acc_resp_ready_o); end
        step();
        acc_resp_valid_i = 1'b0; core_resp_ready_i = '0;
        #1;
        checks++; if (core_req_ready_o !== 4'b0100) begin errors++; $display("FAIL maxout_reenable got %b exp 0100", core_req_ready_o); end
        step();
        idle();
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] s_id; logic [31:0] s_op; logic [DW-1:0] s_a, s_b;
        do_reset();
        rand_payload(); core_req_valid_i = 4'b0011; acc_req_ready_i = 1'b0;
        s_id = core_req_id_i[0]; s_op = core_req_op_i[0]; s_a = core_req_arga_i[0]; s_b = core_req_argb_i[0];
        #1;
        checks++; if (core_req_ready_o !== 4'b0001) begin errors++; $display("FAIL bp_first got %b exp 0001", core_req_ready_o); end
        step();
        for (int i = 0; i < 5; i++) begin
            rand_payload(); #1;
            checks++; if (core_req_ready_o !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d] got %b exp 0000", i, core_req_ready_o); end
            step();
            checks++; if (acc_req_valid_o !== 1'b1 || acc_req_tag_o !== 2'd0 || acc_req_id_o !== s_id || acc_req_op_o !== s_op || acc_req_arga_o !== s_a || acc_req_argb_o !== s_b) begin
                errors++; $display("FAIL bp_hold[%0d] got v%b t%0d id %h op %h exp v1 t0 id %h op %h", i, acc_req_valid_o, acc_req_tag_o, acc_req_id_o, acc_req_op_o, s_id, s_op); end
        end
        acc_req_ready_i = 1'b1; #1;
        checks++; if (core_req_ready_o !== 4'b0010) begin errors++; $display("FAIL bp_release got %b exp 0010", core_req_ready_o); end
        step();
        checks++; if (acc_req_valid_o !== 1'b1 || acc_req_tag_o !== 2'd1) begin errors++; $display("FAIL bp_next_tag got v%b t%0d exp v1 t1", acc_req_valid_o, acc_req_tag_o); end
        idle();
    endtask

    task automatic test_resp_route();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rand_payload(); core_req_valid_i = 4'b1000; acc_req_ready_i = 1'b1;
            model_eval(); #1;
            checks++; if (core_req_ready_o !== exp_ready) begin errors++; $display("FAIL route_fill[%0d] got %b exp %b", i, core_req_ready_o, exp_ready); end
            step();
        end
        acc_resp_valid_i = 1'b1; acc_resp_tag_i = 2'd3; acc_resp_id_i = 5'h0A;
        acc_resp_data_i = 32'hDEAD_BEEF; acc_resp_error_i = 1'b0; core_resp_ready_i = 4'b0111;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (core_resp_valid_o !== 4'b1000 || acc_resp_ready_o !== 1'b0) begin errors++; $display("FAIL route_stall[%0d] got %b/%b exp 1000/0", i, core_resp_valid_o, acc_resp_ready_o); end
            checks++; if (core_resp_id_o !== 5'h0A || core_resp_data_o !== 32'hDEAD_BEEF || core_resp_error_o !== 1'b0) begin errors++; $display("FAIL route_data[%0d] got %h/%h exp 0a/deadbeef", i, core_resp_id_o, core_resp_data_o); end
            checks++; if (core_req_ready_o !== 4'b0000) begin errors++; $display("FAIL route_full[%0d] got %b exp 0000", i, core_req_ready_o); end
            step();
        end
        core_resp_ready_i = 4'b1111; #1;
        checks++; if (acc_resp_ready_o !== 1'b1 || core_resp_valid_o !== 4'b1000) begin errors++; $display("FAIL route_hs got %b/%b exp 1000/1", core_resp_valid_o, acc_resp_ready_o); end
        step();
        acc_resp_valid_i = 1'b0; #1;
        checks++; if (core_req_ready_o !== 4'b1000) begin errors++; $display("FAIL route_dec got %b exp 1000", core_req_ready_o); end
        step();
        idle();
    endtask

    task automatic test_same_cycle();
        logic [N-1:0] seq [3];
        seq = '{4'b0010, 4'b0010, 4'b0000};
        do_reset();
        rand_payload(); core_req_valid_i = 4'b0010; acc_req_ready_i = 1'b1; #1;
        checks++; if (core_req_ready_o !== 4'b0010) begin errors++; $display("FAIL same_first got %b exp 0010", core_req_ready_o); end
        step();
        rand_payload(); acc_resp_valid_i = 1'b1; acc_resp_tag_i = 2'd1; core_resp_ready_i = 4'b0010; #1;
        checks++; if (core_req_ready_o !== 4'b0010 || acc_resp_ready_o !== 1'b1) begin errors++; $display("FAIL same_both got %b/%b exp 0010/1", core_req_ready_o, acc_resp_ready_o); end
        step();
        acc_resp_valid_i = 1'b0; core_resp_ready_i = '0;
        for (int i = 1; i < 3; i++) begin
            rand_payload(); model_eval(); #1;
            checks++; if (core_req_ready_o !== seq[i] || core_req_ready_o !== exp_ready) begin errors++; $display("FAIL same_after[%0d] got %b exp %b", i, core_req_ready_o, seq[i]); end
            step();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] seq [3];
        seq = '{4'b0100, 4'b0100, 4'b0000};
        do_reset();
        rand_payload(); core_req_valid_i = 4'b0100; acc_req_ready_i = 1'b0; #1;
        checks++; if (core_req_ready_o !== 4'b0100) begin errors++; $display("FAIL mid_grant got %b exp 0100", core_req_ready_o); end
        step();
        checks++; if (acc_req_valid_o !== 1'b1) begin errors++; $display("FAIL mid_held got %b exp 1", acc_req_valid_o); end
        rst_i = 1'b1; core_req_valid_i = '1; acc_req_ready_i = 1'b1; #1;
        checks++; if (core_req_ready_o !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", core_req_ready_o); end
        step();
        rst_i = 1'b0; #1;
        checks++; if (acc_req_valid_o !== 1'b0) begin errors++; $display("FAIL mid_cleared got %b exp 0", acc_req_valid_o); end
        checks++; if (core_req_ready_o !== 4'b0001) begin errors++; $display("FAIL mid_rr_restart got %b exp 0001", core_req_ready_o); end
        step();
        for (int i = 0; i < 3; i++) begin
            rand_payload(); core_req_valid_i = 4'b0100; model_eval(); #1;
            checks++; if (core_req_ready_o !== seq[i] || core_req_ready_o !== exp_ready) begin errors++; $display("FAIL mid_cnt_clear[%0d] got %b exp %b", i, core_req_ready_o, seq[i]); end
            step();
        end
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_payload();
            core_req_valid_i  = N'($urandom);
            acc_req_ready_i   = ($urandom_range(0, 3) != 0);
            core_resp_ready_i = N'($urandom);
            acc_resp_data_i   = $urandom;
            acc_resp_error_i  = 1'($urandom);
            if (dq.size() > 0 && $urandom_range(0, 1) == 1) begin
                resp_idx = $urandom_range(0, dq.size() - 1);
                acc_resp_valid_i = 1'b1;
                acc_resp_tag_i = TW'(dq[resp_idx].tag);
                acc_resp_id_i = dq[resp_idx].id;
            end else begin
                resp_idx = -1;
                acc_resp_valid_i = 1'b0;
                acc_resp_tag_i = TW'($urandom);
                acc_resp_id_i = IW'($urandom);
            end
            model_eval(); #1;
            checks++; if (core_req_ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, core_req_ready_o, exp_ready); end
            checks++; if (core_resp_valid_o !== exp_resp_vld || acc_resp_ready_o !== exp_acc_resp_rdy) begin errors++; $display("FAIL rnd_resp[%0d] got %b/%b exp %b/%b", i, core_resp_valid_o, acc_resp_ready_o, exp_resp_vld, exp_acc_resp_rdy); end
            checks++; if (core_resp_id_o !== acc_resp_id_i || core_resp_data_o !== acc_resp_data_i || core_resp_error_o !== acc_resp_error_i) begin errors++; $display("FAIL rnd_pass[%0d] got %h/%h/%b exp %h/%h/%b", i, core_resp_id_o, core_resp_data_o, core_resp_error_o, acc_resp_id_i, acc_resp_data_i, acc_resp_error_i); end
            step();
            checks++; if (acc_req_valid_o !== m_vld) begin errors++; $display("FAIL rnd_vld[%0d] got %b exp %b", i, acc_req_valid_o, m_vld); end
            if (m_vld) begin
                checks++; if (acc_req_tag_o !== TW'(m_tag) || acc_req_id_o !== m_id || acc_req_op_o !== m_op || acc_req_arga_o !== m_a || acc_req_argb_o !== m_b) begin
                    errors++; $display("FAIL rnd_payload[%0d] got t%0d id %h op %h exp t%0d id %h op %h", i, acc_req_tag_o, acc_req_id_o, acc_req_op_o, m_tag, m_id, m_op); end
            end
        end
        idle();
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        rand_payload();
        model_reset();
        test_reset();
        test_rr_order();
        test_max_outstanding();
        test_backpressure();
        test_resp_route();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
